// File: rtl/ralu_seq.sv
// ralu_seq: register-file ALU with an operation sequencer.
//
// Holds NREGS x WIDTH general-purpose registers. A start pulse (taken only
// while idle) latches the opcode and operand selectors. The next cycle fetches
// operands A and B. The operation then executes in one of three ways:
// single-cycle ALU, serial shift/rotate (one bit per cycle), or shift-and-add
// multiply (one bit of B per cycle). After that the sequencer writes the
// result back to the register file and pulses done.
//
// Ports:
//   clock, reset_n         clock, synchronous active-low reset
//   start, op, cin         request pulse, opcode, carry in
//   srca, srcb, dst        operand A / operand B / destination addresses
//   use_imm, imm           select imm as operand B, immediate value
//   shamt, isl, isr        shift amount, fill bits for SHL / SHR
//   wr_en/wr_addr/wr_data  external register write port
//   rd_addr, rd_data       external combinational read port
//   busy, done             sequencer active, one-cycle writeback pulse
//   result, flags          last result and {C,V,N,Z}, held until next writeback
//   osl, osr               last bit shifted out of the MSB / LSB
module ralu_seq #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS),
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             cin,
    input  logic [AW-1:0]    srca,
    input  logic [AW-1:0]    srcb,
    input  logic [AW-1:0]    dst,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    input  logic [SW-1:0]    shamt,
    input  logic             isl,
    input  logic             isr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             osl,
    output logic             osr
);

    // Step counter must hold WIDTH for the multiply, one bit wider than shamt.
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOTA  = 4'h5;
    localparam logic [3:0] OP_PASSB = 4'h6;
    localparam logic [3:0] OP_INC   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_ROL   = 4'hA;
    localparam logic [3:0] OP_ROR   = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] gpr_r [NREGS];

    logic [3:0]       op_r;
    logic             cin_r;
    logic [AW-1:0]    srca_r;
    logic [AW-1:0]    srcb_r;
    logic [AW-1:0]    dst_r;
    logic             use_imm_r;
    logic [WIDTH-1:0] imm_r;
    logic [SW-1:0]    shamt_r;
    logic             isl_r;
    logic             isr_r;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             last_out_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       flags_r;
    logic             osl_r;
    logic             osr_r;
    logic             done_r;
    logic             busy_r;

    logic             is_seq_s;
    logic             is_rsv_s;
    logic [WIDTH+3:0] alu_s;

    // Packs {C,V,N,Z} for a result value.
    function automatic logic [3:0] nz_flags(input logic c, input logic v,
                                            input logic [WIDTH-1:0] r);
        return {c, v, r[WIDTH-1], (r == {WIDTH{1'b0}})};
    endfunction

    // Single-cycle ALU: returns {flags, result}. SUB and INC reuse the adder
    // with an inverted / zero addend so carry and overflow come out uniformly.
    function automatic logic [WIDTH+3:0] alu_op(input logic [3:0]       opc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             c_in);
        logic [WIDTH-1:0] addend;
        logic             carry_in;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        addend   = b;
        carry_in = c_in;
        case (opc)
            OP_SUB:  addend = ~b;
            OP_INC: begin
                addend   = {WIDTH{1'b0}};
                carry_in = 1'b1;
            end
            default: addend = b;
        endcase
        sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};
        res = {WIDTH{1'b0}};
        c   = 1'b0;
        v   = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_INC: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == addend[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOTA:  res = ~a;
            OP_PASSB: res = b;
            default:  res = {WIDTH{1'b0}};
        endcase
        return {nz_flags(c, v, res), res};
    endfunction

    assign is_seq_s = (op_r >= OP_SHL) && (op_r <= OP_MUL);
    assign is_rsv_s = (op_r > OP_MUL);
    assign alu_s    = alu_op(op_r, a_r, b_r, cin_r);

    // Next-state logic of the sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_FETCH;
                else       state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (is_seq_s) state_s = ST_SHIFT;
                else          state_s = ST_EXEC;
            end
            ST_EXEC:  state_s = ST_WB;
            ST_SHIFT: begin
                if (cnt_r == {CW{1'b0}}) state_s = ST_WB;
                else                     state_s = ST_SHIFT;
            end
            ST_WB:    state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register plus registered busy/done derived from next state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_WB);
        end
    end

    // Request latch, operand fetch, execute / serial step, result and flag registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_r       <= 4'h0;
            cin_r      <= 1'b0;
            srca_r     <= {AW{1'b0}};
            srcb_r     <= {AW{1'b0}};
            dst_r      <= {AW{1'b0}};
            use_imm_r  <= 1'b0;
            imm_r      <= {WIDTH{1'b0}};
            shamt_r    <= {SW{1'b0}};
            isl_r      <= 1'b0;
            isr_r      <= 1'b0;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            last_out_r <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            flags_r    <= 4'h0;
            osl_r      <= 1'b0;
            osr_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r      <= op;
                        cin_r     <= cin;
                        srca_r    <= srca;
                        srcb_r    <= srcb;
                        dst_r     <= dst;
                        use_imm_r <= use_imm;
                        imm_r     <= imm;
                        shamt_r   <= shamt;
                        isl_r     <= isl;
                        isr_r     <= isr;
                    end
                end
                ST_FETCH: begin
                    // Operands are copied here so later external writes cannot disturb them.
                    a_r        <= gpr_r[srca_r];
                    b_r        <= use_imm_r ? imm_r : gpr_r[srcb_r];
                    cnt_r      <= (op_r == OP_MUL) ? CW'(WIDTH) : {1'b0, shamt_r};
                    acc_r      <= {WIDTH{1'b0}};
                    last_out_r <= 1'b0;
                end
                ST_EXEC: begin
                    // Reserved opcodes leave result and flags untouched.
                    if (!is_rsv_s) begin
                        result_r <= alu_s[WIDTH-1:0];
                        flags_r  <= alu_s[WIDTH+3:WIDTH];
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        if (op_r == OP_MUL) begin
                            result_r <= acc_r;
                            flags_r  <= nz_flags(1'b0, 1'b0, acc_r);
                        end else begin
                            result_r <= b_r;
                            flags_r  <= nz_flags(last_out_r, 1'b0, b_r);
                        end
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                        case (op_r)
                            OP_SHL: begin
                                b_r        <= {b_r[WIDTH-2:0], isl_r};
                                last_out_r <= b_r[WIDTH-1];
                                osl_r      <= b_r[WIDTH-1];
                            end
                            OP_SHR: begin
                                b_r        <= {isr_r, b_r[WIDTH-1:1]};
                                last_out_r <= b_r[0];
                                osr_r      <= b_r[0];
                            end
                            OP_ROL: begin
                                b_r        <= {b_r[WIDTH-2:0], b_r[WIDTH-1]};
                                last_out_r <= b_r[WIDTH-1];
                                osl_r      <= b_r[WIDTH-1];
                            end
                            OP_ROR: begin
                                b_r        <= {b_r[0], b_r[WIDTH-1:1]};
                                last_out_r <= b_r[0];
                                osr_r      <= b_r[0];
                            end
                            OP_MUL: begin
                                // Shift-and-add: A walks left, B walks right.
                                if (b_r[0]) acc_r <= acc_r + a_r;
                                a_r <= {a_r[WIDTH-2:0], 1'b0};
                                b_r <= {1'b0, b_r[WIDTH-1:1]};
                            end
                            default: b_r <= b_r;
                        endcase
                    end
                end
                ST_WB: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Register file: external write first, so a same-address writeback overrides it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) gpr_r[i] <= {WIDTH{1'b0}};
        end else begin
            if (wr_en) gpr_r[wr_addr] <= wr_data;
            if ((state_r == ST_WB) && !is_rsv_s) gpr_r[dst_r] <= result_r;
        end
    end

    assign rd_data = gpr_r[rd_addr];
    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign flags   = flags_r;
    assign osl     = osl_r;
    assign osr     = osr_r;

endmodule

// File: tb/tb_ralu_seq.sv
// Bench for ralu_seq: transaction-level reference model plus per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ralu_seq;

    localparam int W  = 8;
    localparam int NR = 8;
    localparam int M  = 255;

    logic       clock = 1'b0;
    logic       reset_n, start, cin, use_imm, isl, isr, wr_en;
    logic [3:0] op;
    logic [2:0] srca, srcb, dst, wr_addr, rd_addr, shamt;
    logic [7:0] imm, wr_data;
    logic [7:0] rd_data, result;
    logic [3:0] flags;
    logic       busy, done, osl, osr;

    always #5 clock = ~clock;

    ralu_seq #(.WIDTH(W), .NREGS(NR)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op), .cin(cin),
        .srca(srca), .srcb(srcb), .dst(dst), .use_imm(use_imm), .imm(imm),
        .shamt(shamt), .isl(isl), .isr(isr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .result(result), .flags(flags), .osl(osl), .osr(osr)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic int sgn(input int x);
        return (x >= (1 << (W-1))) ? x - (1 << W) : x;
    endfunction

    function automatic void predict(input logic [3:0] opc, input int a, input int b,
                                    input int ci, input int k, input int il, input int ir,
                                    output int res, output int flg);
        int s, bb, cc, c, v, ss;
        c = 0; v = 0; res = 0;
        case (opc)
            4'h0, 4'h1, 4'h7: begin
                bb = (opc == 4'h1) ? (~b & M) : ((opc == 4'h7) ? 0 : b);
                cc = (opc == 4'h7) ? 1 : ci;
                s   = a + bb + cc;
                res = s & M;
                c   = (s >> W) & 1;
                ss  = sgn(a) + sgn(bb) + cc;
                v   = (ss > 127 || ss < -128) ? 1 : 0;
            end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = ~a & M;
            4'h6: res = b;
            4'h8: begin
                res = ((b << k) | (il != 0 ? ((1 << k) - 1) : 0)) & M;
                c   = (k == 0) ? 0 : (b >> (W-k)) & 1;
            end
            4'h9: begin
                res = (b >> k) | (ir != 0 ? (M & ~(M >> k)) : 0);
                c   = (k == 0) ? 0 : (b >> (k-1)) & 1;
            end
            4'hA: begin
                res = ((b << k) | (b >> (W-k))) & M;
                c   = (k == 0) ? 0 : (b >> (W-k)) & 1;
            end
            4'hB: begin
                res = ((b >> k) | (b << (W-k))) & M;
                c   = (k == 0) ? 0 : (b >> (k-1)) & 1;
            end
            4'hC: res = (a * b) & M;
            default: res = 0;
        endcase
        flg = (c << 3) | (v << 2) | (((res >> (W-1)) & 1) << 1) | ((res == 0) ? 1 : 0);
    endfunction

    logic [7:0] m_gpr [NR];
    logic       m_valid = 1'b0;
    logic       m_busy, m_done, m_osl, m_osr;
    logic [7:0] m_result;
    logic [3:0] m_flags;
    logic       tx_active = 1'b0;
    int         tx_rel, tx_D, tx_k, t_a, t_b, t_res, t_flg, jstep;
    logic [3:0] tx_op;
    logic       tx_cin, tx_ui, tx_il, tx_ir, tx_rsv, do_wb;
    logic [2:0] tx_sa, tx_sb, tx_dst;
    logic [7:0] tx_imm;

    // Model update: one edge at a time, in terms of the transaction timeline.
    always @(posedge clock) begin
        cyc++;
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) m_gpr[i] = 8'h00;
            m_busy = 1'b0; m_done = 1'b0; m_result = 8'h00; m_flags = 4'h0;
            m_osl = 1'b0; m_osr = 1'b0; tx_active = 1'b0; m_valid = 1'b1;
        end else begin
            do_wb = 1'b0;
            if (tx_active) begin
                tx_rel++;
                if (tx_rel == 1) begin
                    t_a = int'(m_gpr[tx_sa]);
                    t_b = tx_ui ? int'(tx_imm) : int'(m_gpr[tx_sb]);
                    predict(tx_op, t_a, t_b, int'(tx_cin), tx_k, int'(tx_il), int'(tx_ir), t_res, t_flg);
                end
                if (tx_op >= 4'h8 && tx_op <= 4'hB && tx_rel >= 2 && tx_rel <= tx_k + 1) begin
                    jstep = tx_rel - 1;
                    if (tx_op == 4'h8 || tx_op == 4'hA) m_osl = 1'((t_b >> (W - jstep)) & 1);
                    else                                m_osr = 1'((t_b >> (jstep - 1)) & 1);
                end
                if (tx_rel == tx_D - 1) begin
                    m_done = 1'b1;
                    if (!tx_rsv) begin
                        m_result = 8'(t_res);
                        m_flags  = 4'(t_flg);
                    end
                end
                if (tx_rel == tx_D) begin
                    m_done = 1'b0; m_busy = 1'b0; tx_active = 1'b0; do_wb = !tx_rsv;
                end
            end else if (start) begin
                tx_op = op; tx_cin = cin; tx_sa = srca; tx_sb = srcb; tx_dst = dst;
                tx_ui = use_imm; tx_imm = imm; tx_k = int'(shamt); tx_il = isl; tx_ir = isr;
                tx_rsv = (op > 4'hC);
                tx_D = (op >= 4'h8 && op <= 4'hB) ? 3 + tx_k : ((op == 4'hC) ? 3 + W : 3);
                tx_rel = 0; tx_active = 1'b1; m_busy = 1'b1;
            end
            if (wr_en) m_gpr[wr_addr] = wr_data;
            if (do_wb) m_gpr[tx_dst] = 8'(t_res);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("busy",    32'(busy),    32'(m_busy));
            chk("done",    32'(done),    32'(m_done));
            chk("result",  32'(result),  32'(m_result));
            chk("flags",   32'(flags),   32'(m_flags));
            chk("osl",     32'(osl),     32'(m_osl));
            chk("osr",     32'(osr),     32'(m_osr));
            chk("rd_data", 32'(rd_data), 32'(m_gpr[rd_addr]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic ext_wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    // Issue one operation; optional external write to dst and extra start in given cycles.
    task automatic run_op(input logic [3:0] o, input logic c, input int sa, input int sb,
                          input int d, input logic ui, input int im, input int sh,
                          input logic il, input int poke_wr, input int poke_st,
                          output int dcyc);
        op = o; cin = c; srca = 3'(sa); srcb = 3'(sb); dst = 3'(d); use_imm = ui;
        imm = 8'(im); shamt = 3'(sh); isl = il; isr = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        dcyc = -1;
        for (int n = 1; n <= 40; n++) begin
            wr_en = (n == poke_wr); wr_addr = 3'(d); wr_data = 8'h55;
            start = (n == poke_st);
            if (n == poke_st) op = 4'h0;
            settle();
            if (done === 1'b1) begin
                dcyc = n;
                break;
            end
            tick();
        end
        tick();
        wr_en = 1'b0; start = 1'b0;
    endtask

    int dc, cnt;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 4'h0; cin = 1'b0; srca = 3'd0; srcb = 3'd0;
        dst = 3'd0; use_imm = 1'b0; imm = 8'h00; shamt = 3'd0; isl = 1'b0; isr = 1'b0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; rd_addr = 3'd0;
        tick(); tick();
        reset_n = 1'b1;

        // 1: reset state
        for (int a = 0; a < NR; a++) begin
            rd_addr = 3'(a);
            settle();
            chk("reset_rd", 32'(rd_data), 32'h00);
            tick();
        end
        settle();
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_flags", 32'(flags), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        tick();

        // 2: ADD overflow
        ext_wr(1, 8'h7F); ext_wr(2, 8'h01);
        run_op(4'h0, 1'b0, 1, 2, 3, 1'b0, 0, 0, 1'b0, 0, 0, dc);
        chk("add_done_cycle", 32'(dc), 32'd3);
        chk("add_result", 32'(result), 32'h80);
        chk("add_flags", 32'(flags), 32'h6);
        chk("model_add_result", 32'(m_result), 32'h80);
        rd_addr = 3'd3;
        settle();
        chk("add_r3_cycle4", 32'(rd_data), 32'h80);
        tick();

        // 3: SUB to zero, with an ignored start in cycle 2
        run_op(4'h1, 1'b1, 1, 1, 4, 1'b0, 0, 0, 1'b0, 0, 2, dc);
        chk("sub_done_cycle", 32'(dc), 32'd3);
        chk("sub_result", 32'(result), 32'h00);
        chk("sub_flags", 32'(flags), 32'h9);
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            settle();
            if (done === 1'b1) cnt++;
            tick();
        end
        chk("sub_no_extra_done", 32'(cnt), 32'd0);

        // 4: ROR and SHL with immediate
        run_op(4'hB, 1'b0, 0, 0, 5, 1'b1, 8'h81, 1, 1'b0, 0, 0, dc);
        chk("ror_done_cycle", 32'(dc), 32'd4);
        chk("ror_result", 32'(result), 32'hC0);
        chk("ror_flags", 32'(flags), 32'hA);
        chk("ror_osr", 32'(osr), 32'h1);
        run_op(4'h8, 1'b0, 0, 0, 5, 1'b1, 8'h81, 3, 1'b0, 0, 0, dc);
        chk("shl_done_cycle", 32'(dc), 32'd6);
        chk("shl_result", 32'(result), 32'h08);
        chk("shl_flags", 32'(flags), 32'h0);

        // 5: MUL, then write-port collision on WB
        ext_wr(4, 8'h0D); ext_wr(5, 8'h0B);
        run_op(4'hC, 1'b0, 4, 5, 7, 1'b0, 0, 0, 1'b0, 0, 0, dc);
        chk("mul_done_cycle", 32'(dc), 32'd11);
        chk("mul_result", 32'(result), 32'h8F);
        chk("mul_flags", 32'(flags), 32'h2);
        chk("model_mul_result", 32'(m_result), 32'h8F);
        run_op(4'h0, 1'b0, 1, 2, 6, 1'b0, 0, 0, 1'b0, 3, 0, dc);
        rd_addr = 3'd6;
        settle();
        chk("collision_r6", 32'(rd_data), 32'h80);
        tick();

        // 6: reset during a long shift
        op = 4'h8; srcb = 3'd1; use_imm = 1'b0; shamt = 3'd7; dst = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        settle();
        chk("abort_busy", 32'(busy), 32'h0);
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            settle();
            if (done === 1'b1) cnt++;
            tick();
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        rd_addr = 3'd0;
        settle();
        chk("abort_dst", 32'(rd_data), 32'h00);
        tick();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            start   = ($urandom_range(0, 2) == 0);
            op      = 4'($urandom_range(0, 15));
            cin     = 1'($urandom_range(0, 1));
            srca    = 3'($urandom_range(0, 7));
            srcb    = 3'($urandom_range(0, 7));
            dst     = 3'($urandom_range(0, 7));
            use_imm = 1'($urandom_range(0, 1));
            imm     = 8'($urandom_range(0, 255));
            shamt   = 3'($urandom_range(0, 7));
            isl     = 1'($urandom_range(0, 1));
            isr     = 1'($urandom_range(0, 1));
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom_range(0, 255));
            rd_addr = 3'($urandom_range(0, 7));
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset_n = 1'b1; start = 1'b0; wr_en = 1'b0;
        for (int n = 0; n < 20; n++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
